// File: rtl/nerv_dmem_wb_bridge.sv
// rtl/nerv_dmem_wb_bridge.sv - NERV data-memory port to single-outstanding classic Wishbone master
// Optional ack timeout with sticky bus_err_o: define NERV_DMEM_BRIDGE_TIMEOUT_EN.
module nerv_dmem_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  dmem_valid_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [3:0]            dmem_wstrb_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  stall_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i,
    output logic                  bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [3:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [1:0] unused_addr_lsbs;
    assign unused_addr_lsbs = dmem_addr_i[1:0];

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // Freeze the core in the very cycle it raises the request.
                stall_o = dmem_valid_i;
                if (dmem_valid_i) begin
                    addr_d  = {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    we_d    = |dmem_wstrb_i;
                    sel_d   = (|dmem_wstrb_i) ? dmem_wstrb_i : 4'hF;
                    wdata_d = dmem_wdata_i;
                    cyc_d   = 1'b1;
                    state_d = BUS;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end
            end
            BUS: begin
                stall_o = 1'b1;
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = wb_data_i;
                    end
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon a silent slave; the core sees a poison read value.
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = DATA_WIDTH'(32'hDEADBEEF);
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = wdata_q;
    assign dmem_rdata_o = rdata_q;

endmodule

// File: tb/tb_nerv_dmem_wb_bridge.sv
// tb/tb_nerv_dmem_wb_bridge.sv - randomized self-checking bench for nerv_dmem_wb_bridge
// Timeout scenarios follow NERV_DMEM_BRIDGE_TIMEOUT_EN; instance uses TIMEOUT_CYCLES=8.
module tb_nerv_dmem_wb_bridge;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        dmem_valid_i;
    logic [31:0] dmem_addr_i;
    logic [3:0]  dmem_wstrb_i;
    logic [31:0] dmem_wdata_i;
    logic [31:0] dmem_rdata_o;
    logic        stall_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        bus_err_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_rdata;
    logic        model_err;

    always #5 sys_clk = ~sys_clk;

    nerv_dmem_wb_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .dmem_valid_i(dmem_valid_i),
        .dmem_addr_i (dmem_addr_i),
        .dmem_wstrb_i(dmem_wstrb_i),
        .dmem_wdata_i(dmem_wdata_i),
        .dmem_rdata_o(dmem_rdata_o),
        .stall_o     (stall_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i),
        .bus_err_o   (bus_err_o)
    );

    // One full core access, entered at the falling edge of an idle cycle.
    // The slave acks on BUS cycle number w (0 = zero-wait).
    task automatic transact(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input int w,
                            input logic [31:0] slave_rd, input bit keep_valid);
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
        int          stall_cnt;
        int          cyc_cnt;
        bit          fin;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = (wstrb != 4'h0);
        exp_sel   = exp_we ? wstrb : 4'hF;
        exp_rdata = exp_we ? model_rdata : slave_rd;
        dmem_valid_i = 1'b1;
        dmem_addr_i  = addr;
        dmem_wstrb_i = wstrb;
        dmem_wdata_i = wdata;
        stall_cnt = 0;
        cyc_cnt   = 0;
        fin       = 1'b0;
        for (int k = 0; k < w + 20 && !fin; k++) begin
            if (k == 0) begin
                vectors++;
                if (wb_cyc_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_cyc: got %b expected 0", wb_cyc_o);
                end
            end
            if (wb_cyc_o) begin
                vectors++;
                if ({wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o} !==
                    {1'b1, exp_we, exp_sel, exp_addr, wdata}) begin
                    miscompares++;
                    $display("FAIL bus_fields: got stb=%b we=%b sel=%h addr=%h data=%h expected stb=1 we=%b sel=%h addr=%h data=%h",
                             wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
                             exp_we, exp_sel, exp_addr, wdata);
                end
                wb_ack_i  = (cyc_cnt == w);
                wb_data_i = wb_ack_i ? slave_rd : $urandom;
                cyc_cnt++;
            end else begin
                wb_ack_i  = 1'b0;
                wb_data_i = $urandom;
            end
            #1;
            if (stall_o) stall_cnt++;
            else fin = 1'b1;
            if (!fin) @(negedge sys_clk);
        end
        wb_ack_i = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL release_timeout: stall never dropped within %0d cycles", w + 20);
        end
        vectors++;
        if (cyc_cnt != w + 1) begin
            miscompares++;
            $display("FAIL cyc_length: got %0d expected %0d", cyc_cnt, w + 1);
        end
        vectors++;
        if (stall_cnt != w + 2) begin
            miscompares++;
            $display("FAIL stall_length: got %0d expected %0d", stall_cnt, w + 2);
        end
        vectors++;
        if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL done_cyc: got %b expected 00", {wb_cyc_o, wb_stb_o});
        end
        vectors++;
        if (dmem_rdata_o !== exp_rdata) begin
            miscompares++;
            $display("FAIL done_rdata: got %h expected %h", dmem_rdata_o, exp_rdata);
        end
        vectors++;
        if (bus_err_o !== model_err) begin
            miscompares++;
            $display("FAIL done_err: got %b expected %b", bus_err_o, model_err);
        end
        model_rdata = exp_rdata;
        if (!keep_valid) dmem_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        dmem_valid_i = 1'b0;
        dmem_addr_i  = 32'h0;
        dmem_wstrb_i = 4'h0;
        dmem_wdata_i = 32'h0;
        wb_data_i    = 32'h0;
        wb_ack_i     = 1'b0;
        #3;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
             dmem_rdata_o, bus_err_o, stall_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b sel=%h addr=%h data=%h rdata=%h err=%b stall=%b expected all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
                     dmem_rdata_o, bus_err_o, stall_o);
        end
        @(negedge sys_clk);
        rst_n       = 1'b1;
        model_rdata = 32'h0;
        model_err   = 1'b0;
    endtask

    task automatic test_zero_wait_read();
        @(negedge sys_clk);
        transact(32'h0000_1006, 4'h0, 32'h1234_5678, 0, 32'hCAFE_BABE, 1'b0);
    endtask

    task automatic test_byte_write();
        @(negedge sys_clk);
        transact(32'h2000_0013, 4'b0100, 32'h00AB_0000, 3, 32'h5555_AAAA, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge sys_clk);
        transact(32'h0000_0040, 4'h0, 32'h0, 1, 32'h0BAD_F00D, 1'b1);
        @(negedge sys_clk);
        transact(32'h0000_0044, 4'b1111, 32'hFEED_FACE, 0, 32'h1111_2222, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            @(negedge sys_clk);
            transact($urandom, ws, $urandom, int'($urandom_range(0, 5)), $urandom,
                     bit'($urandom_range(0, 1)));
        end
        dmem_valid_i = 1'b0;
    endtask

    task automatic test_stray_ack();
        @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            wb_ack_i  = 1'b1;
            wb_data_i = $urandom;
            #1;
            vectors++;
            if ({stall_o, wb_cyc_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL stray_ack_idle: got stall=%b cyc=%b expected 0 0", stall_o, wb_cyc_o);
            end
            @(negedge sys_clk);
        end
        wb_ack_i = 1'b0;
        vectors++;
        if (dmem_rdata_o !== model_rdata) begin
            miscompares++;
            $display("FAIL stray_ack_rdata: got %h expected %h", dmem_rdata_o, model_rdata);
        end
        transact(32'h0000_0100, 4'h0, 32'h0, 2, 32'h7777_8888, 1'b0);
    endtask

    task automatic test_timeout();
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        int  stall_cnt;
        int  cyc_cnt;
        bit  fin;
        @(negedge sys_clk);
        transact(32'h0000_0200, 4'h0, 32'h0, 7, 32'hA5A5_5A5A, 1'b0);
        @(negedge sys_clk);
        dmem_valid_i = 1'b1;
        dmem_addr_i  = 32'h0000_0300;
        dmem_wstrb_i = 4'h0;
        wb_ack_i     = 1'b0;
        stall_cnt = 0;
        cyc_cnt   = 0;
        fin       = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            if (wb_cyc_o) cyc_cnt++;
            #1;
            if (stall_o) stall_cnt++;
            else fin = 1'b1;
            if (!fin) @(negedge sys_clk);
        end
        dmem_valid_i = 1'b0;
        vectors++;
        if (!fin || cyc_cnt != 8 || stall_cnt != 9) begin
            miscompares++;
            $display("FAIL timeout_length: got fin=%b cyc=%0d stall=%0d expected 1 8 9", fin, cyc_cnt, stall_cnt);
        end
        vectors++;
        if (dmem_rdata_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL timeout_rdata: got %h expected deadbeef", dmem_rdata_o);
        end
        vectors++;
        if (bus_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err: got %b expected 1", bus_err_o);
        end
        model_rdata = 32'hDEAD_BEEF;
        model_err   = 1'b1;
        @(negedge sys_clk);
        transact(32'h0000_0304, 4'b0011, 32'h1234_ABCD, 1, 32'h0, 1'b0);
`else
        int miss;
        logic [31:0] late;
        @(negedge sys_clk);
        dmem_valid_i = 1'b1;
        dmem_addr_i  = 32'h0000_0300;
        dmem_wstrb_i = 4'h0;
        wb_ack_i     = 1'b0;
        miss = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge sys_clk);
            #1;
            if (!stall_o || !wb_cyc_o) miss++;
        end
        dmem_valid_i = 1'b0;
        vectors++;
        if (miss != 0) begin
            miscompares++;
            $display("FAIL no_timeout_hold: got %0d released cycles expected 0", miss);
        end
        vectors++;
        if (bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout_err: got %b expected 0", bus_err_o);
        end
        late      = $urandom;
        wb_ack_i  = 1'b1;
        wb_data_i = late;
        @(negedge sys_clk);
        wb_ack_i = 1'b0;
        #1;
        vectors++;
        if ({stall_o, dmem_rdata_o} !== {1'b0, late}) begin
            miscompares++;
            $display("FAIL late_ack: got stall=%b rdata=%h expected 0 %h", stall_o, dmem_rdata_o, late);
        end
        model_rdata = late;
`endif
    endtask

    task automatic test_reset_mid_bus();
        @(negedge sys_clk);
        dmem_valid_i = 1'b1;
        dmem_addr_i  = 32'h0000_0400;
        dmem_wstrb_i = 4'h0;
        wb_ack_i     = 1'b0;
        @(negedge sys_clk);
        dmem_valid_i = 1'b0;
        vectors++;
        if (wb_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_bus_cyc: got %b expected 1", wb_cyc_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, dmem_rdata_o, bus_err_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got cyc=%b stb=%b rdata=%h err=%b expected 0 0 0 0",
                     wb_cyc_o, wb_stb_o, dmem_rdata_o, bus_err_o);
        end
        model_rdata = 32'h0;
        model_err   = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            #1;
            vectors++;
            if ({wb_cyc_o, stall_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset_idle: got cyc=%b stall=%b expected 0 0", wb_cyc_o, stall_o);
            end
        end
        @(negedge sys_clk);
        transact(32'h0000_0408, 4'b1000, 32'h8800_0000, 0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_byte_write();
        test_back_to_back();
        test_random();
        test_stray_ack();
        test_timeout();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nerv_dmem_wb_bridge.md
Name: nerv_dmem_wb_bridge

Overview:
- Converts the NERV core data-memory port (valid/addr/wstrb/wdata/rdata) into a single-outstanding classic Wishbone master transaction on the data_mem bus.
- Sits between the core and the Controller's second memory port (`data_mem_*`).
- Freezes the core through its stall input while the bus transaction is in flight.
- Replaces the direct tie-off of cyc/stb to 1 and we to valid, so that reads, byte writes and slow slaves are handled correctly.

Parameters:
- ADDR_WIDTH, 32, width of the core and bus address.
- DATA_WIDTH, 32, data width; must be 32, since sel is 4 bits.
- TIMEOUT_CYCLES, 255, cycles waited for ack before abort; only used when the timeout feature is compiled in; range 1..65535.

Ports:
- sys_clk  input  1  core clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dmem_valid_i  input  1  core requests a data access this cycle.
- dmem_addr_i  input  ADDR_WIDTH  byte address from the core.
- dmem_wstrb_i  input  4  byte write strobes; 0 means read.
- dmem_wdata_i  input  DATA_WIDTH  write data from the core.
- dmem_rdata_o  output  DATA_WIDTH  read data returned to the core.
- stall_o  output  1  drives the core stall input.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  1 = write.
- wb_sel_o  output  4  byte select.
- wb_addr_o  output  ADDR_WIDTH  address; bits [1:0] forced to 0.
- wb_data_o  output  DATA_WIDTH  write data.
- wb_data_i  input  DATA_WIDTH  read data.
- wb_ack_i  input  1  transaction acknowledge.
- bus_err_o  output  1  sticky flag, set on timeout; stays 0 when the feature is off.

Behaviour:
- Reset values (async, while rst_n=0):
  - state=IDLE.
  - wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_addr_o=0, wb_data_o=0.
  - dmem_rdata_o=0, bus_err_o=0, timeout counter=0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall_o = dmem_valid_i (combinational), so the core freezes in the same cycle it issues the request.
  - On dmem_valid_i=1, register the request:
    - wb_addr_o = {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00}.
    - wb_we_o = |dmem_wstrb_i.
    - wb_sel_o = wstrb if nonzero, else 4'hF.
    - wb_data_o = dmem_wdata_i.
  - Assert wb_cyc_o and wb_stb_o, then go to BUS.
- BUS:
  - stall_o=1; cyc, stb and all request fields are held stable.
  - On wb_ack_i=1:
    - Drop cyc and stb on the next edge.
    - For reads, capture dmem_rdata_o <= wb_data_i.
    - For writes, dmem_rdata_o is unchanged.
    - Go to DONE.
- DONE (1 cycle):
  - stall_o=0 so the core advances exactly one instruction with dmem_rdata_o valid and stable.
  - Requests in DONE are not accepted; next state is IDLE.
  - A request still asserted in the following IDLE cycle is treated as new.
- Latency: minimum 3 cycles from valid to core release with a zero-wait slave (IDLE→BUS, ack, DONE).
- Ack handling:
  - wb_ack_i outside BUS is ignored.
  - An ack in the same cycle cyc first rises (i.e., while in IDLE) is not possible by construction.
  - dmem_rdata_o holds its last value until the next read ack.
- Reset mid-transaction: cyc and stb drop immediately, without a clock edge. The core is reset in the same domain, so no response is owed.
- dmem_valid_i deasserting while in BUS does not abort the transfer.
- No pipelining: at most one outstanding transaction.

Optional Feature:
- Macro: NERV_DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on BUS entry and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, cyc and stb drop and the bridge goes to DONE.
  - dmem_rdata_o is forced to 32'hDEADBEEF on a read; on a write it is unchanged.
  - bus_err_o is set to 1 and held until reset.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter is built, BUS waits indefinitely, and bus_err_o is tied to 0.

Test Plan:
- Zero-wait read: valid, addr=0x0000_1006, wstrb=0; slave acks the first BUS cycle with 0xCAFEBABE -> wb_addr_o=0x0000_1004, sel=F, we=0; stall high 2 cycles; dmem_rdata_o=0xCAFEBABE in DONE.
- Byte write: wstrb=4'b0100, wdata=0x00AB0000; ack after 3 wait cycles -> we=1, sel=4'b0100; cyc held exactly 4 cycles; stall released after ack+1; rdata unchanged.
- Back-to-back: core keeps valid high across two requests (read then write) -> two distinct cyc pulses separated by at least one IDLE cycle; no merged transfer.
- Async reset mid-BUS: drop rst_n with no clock -> cyc=stb=0 immediately; after release, state is IDLE with no spurious cycle.
- Timeout, macro on, TIMEOUT_CYCLES=8, slave never acks a read -> cyc drops after 8 BUS cycles; rdata=0xDEADBEEF; bus_err_o=1 and sticky. With the macro off, stall stays high for 1000 cycles.
- Stray ack in IDLE (ack pulsed with no request) -> no state change; rdata unchanged; stall=0.
